// File: rtl/mem_lsu_if.sv
// Core request/response channel plus the word-wide memory port of the load/store unit.
// slave is the LSU's view; master is the core/memory side that drives requests and read data.
interface mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [31:0] mem_adr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [1:0]  mem_mode;
    logic [31:0] mem_rd;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, mem_adr, mem_wd, mem_we, mem_mode
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, mem_adr, mem_wd, mem_we, mem_mode
    );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit: splits misaligned accesses into word reads or byte writes against a
// word-organised memory and returns extended load data with a one-cycle response pulse.
module mem_lsu (
    input  logic      clk,
    input  logic      reset_n,
    mem_lsu_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, LD0, LD1, ST, STB, RESP} state_t;

    state_t      state, state_nx;
    logic [1:0]  cnt, cnt_nx;
    logic [31:0] buf0, buf1, rdata;
    logic        r_we, r_uns;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata;

    logic        req_aligned, is_word, crossing;
    logic [1:0]  last_byte;
    logic [63:0] window;
    logic [31:0] shifted, ext;

    assign req_aligned = (bus.req_size == 2'b10) ||
                         (bus.req_size == 2'b01 && !bus.req_addr[0]) ||
                         (bus.req_addr[1:0] == 2'b00);
    assign is_word     = (r_size[1] == r_size[0]);
    assign crossing    = (r_size == 2'b01 && r_addr[1:0] == 2'b11) ||
                         (is_word && r_addr[1:0] != 2'b00);
    assign last_byte   = (r_size == 2'b01) ? 2'd1 : 2'd3;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (bus.req_valid)
                      state_nx = bus.req_we ? (req_aligned ? ST : STB) : LD0;
            LD0:  state_nx = crossing ? LD1 : RESP;
            LD1:  state_nx = RESP;
            ST:   state_nx = RESP;
            STB: begin
                if (cnt == last_byte) begin
                    state_nx = RESP;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 2'd1;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state == IDLE);
        bus.resp_valid = (state == RESP);
        bus.resp_rdata = rdata;
        bus.mem_we     = 1'b0;
        bus.mem_mode   = 2'b00;
        bus.mem_wd     = '0;
        bus.mem_adr    = '0;
        case (state)
            LD0: bus.mem_adr = {r_addr[31:2], 2'b00};
            LD1: bus.mem_adr = {r_addr[31:2], 2'b00} + 32'd4;
            ST: begin
                bus.mem_we   = 1'b1;
                bus.mem_adr  = r_addr;
                bus.mem_mode = (r_size == 2'b11) ? 2'b00 : r_size;
                bus.mem_wd   = r_wdata;
            end
            STB: begin
                bus.mem_we   = 1'b1;
                bus.mem_adr  = r_addr + {30'b0, cnt};
                bus.mem_mode = 2'b10;
                bus.mem_wd   = {24'b0, r_wdata[{cnt, 3'b000} +: 8]};
            end
            default: ;
        endcase
    end

    // The final read word is folded in straight from mem_rd so rdata is valid during RESP.
    always_comb begin
        window  = {(state == LD1) ? bus.mem_rd : buf1, (state == LD0) ? bus.mem_rd : buf0};
        shifted = 32'(window >> {r_addr[1:0], 3'b000});
        case (r_size)
            2'b10:   ext = r_uns ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   ext = r_uns ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            buf0    <= '0;
            buf1    <= '0;
            rdata   <= '0;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && bus.req_valid) begin
                r_we    <= bus.req_we;
                r_uns   <= bus.req_unsigned;
                r_size  <= bus.req_size;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end
            if (state == LD0) buf0 <= bus.mem_rd;
            if (state == LD1) buf1 <= bus.mem_rd;
            if (state_nx == RESP) rdata <= r_we ? '0 : ext;
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: a byte-array memory on the memory port, directed vector table,
// hand-written corner sequences and randomized accesses against a byte-level reference.
module tb_mem_lsu;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mem_lsu_if bus();
    mem_lsu u_dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    logic [7:0] mb [64];   // memory attached to the DUT
    logic [7:0] rb [64];   // reference image updated from the access rules

    assign bus.mem_rd = {mb[{bus.mem_adr[5:2], 2'b11}], mb[{bus.mem_adr[5:2], 2'b10}],
                         mb[{bus.mem_adr[5:2], 2'b01}], mb[{bus.mem_adr[5:2], 2'b00}]};

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [1:0]  mode;
        logic [31:0] adr;
        logic [31:0] wd;
    } mcyc_t;
    mcyc_t trace[$];

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
        logic [31:0] exp_adr0;
        logic [31:0] exp_w10;
        logic [31:0] exp_w14;
    } vec_t;
    vec_t tab [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b10) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] mem_word(input logic [5:0] a);
        return {mb[a + 6'd3], mb[a + 6'd2], mb[a + 6'd1], mb[a]};
    endfunction

    task automatic preload();
        logic [31:0] w10, w14;
        w10 = 32'h8899AABB;
        w14 = 32'h11223344;
        for (int i = 0; i < 64; i++) begin
            mb[i] = 8'h00;
            rb[i] = 8'h00;
        end
        for (int k = 0; k < 4; k++) begin
            mb[16 + k] = w10[8*k +: 8];
            rb[16 + k] = w10[8*k +: 8];
            mb[20 + k] = w14[8*k +: 8];
            rb[20 + k] = w14[8*k +: 8];
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size, input logic uns);
        int n;
        logic [31:0] v, mask;
        n = nbytes(size);
        v = 0;
        for (int k = 0; k < n; k++) v = v | ({24'b0, rb[6'(addr + k)]} << (8 * k));
        mask = (n == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * n)) - 32'd1);
        if (!uns && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
        for (int k = 0; k < nbytes(size); k++) rb[6'(addr + k)] = wdata[8*k +: 8];
    endtask

    function automatic int ref_latency(input logic we, input logic [31:0] addr, input logic [1:0] size);
        int n, off;
        n = nbytes(size);
        off = int'(addr[1:0]);
        if (!we) return (off + n > 4) ? 3 : 2;
        return (int'(addr % n) == 0) ? 2 : n + 1;
    endfunction

    // Advance one clock: sample the write the DUT presents, commit it just after the edge.
    task automatic step();
        logic w;
        logic [31:0] a, d;
        logic [1:0] m;
        int n;
        w = bus.mem_we;
        a = bus.mem_adr;
        d = bus.mem_wd;
        m = bus.mem_mode;
        @(posedge clk);
        #1;
        if (w && reset_n) begin
            n = (m == 2'b10) ? 1 : (m == 2'b01) ? 2 : 4;
            for (int k = 0; k < n; k++) mb[6'(a + k)] = d[8*k +: 8];
        end
        @(negedge clk);
    endtask

    task automatic access(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input bit junk,
                          output int lat, output logic [31:0] rdata);
        trace.delete();
        lat = 0;
        rdata = '0;
        check("req_ready_idle", bus.req_ready, 1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        step();
        for (int c = 1; c <= 12; c++) begin
            if (junk) begin
                bus.req_valid    = 1'($urandom_range(0, 1));
                bus.req_we       = 1'($urandom);
                bus.req_size     = 2'($urandom);
                bus.req_addr     = $urandom;
                bus.req_wdata    = $urandom;
            end else begin
                bus.req_valid = 1'b0;
            end
            trace.push_back('{bus.mem_we, bus.mem_mode, bus.mem_adr, bus.mem_wd});
            if (!bus.mem_we) begin
                check("nowrite_mode", {30'b0, bus.mem_mode}, 0);
                check("nowrite_wd", bus.mem_wd, 0);
            end
            if (bus.resp_valid) begin
                lat = c;
                rdata = bus.resp_rdata;
                bus.req_valid = 1'b0;
                step();
                break;
            end
            check("req_ready_busy", bus.req_ready, 0);
            step();
        end
        check("resp_seen", {31'b0, lat != 0}, 1);
        check("resp_pulse_end", bus.resp_valid, 0);
        check("rdata_hold", bus.resp_rdata, rdata);
        check("idle_adr", bus.mem_adr, 0);
    endtask

    initial begin
        int lat, n_bad;
        logic [31:0] rd, exp_rd;
        logic [31:0] wdv;

        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        preload();

        reset_n = 1'b0;
        #2;
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_adr", bus.mem_adr, 0);
        check("rst_mem_wd", bus.mem_wd, 0);
        check("rst_mem_mode", {30'b0, bus.mem_mode}, 0);
        check("rst_resp_rdata", bus.resp_rdata, 0);
        @(negedge clk);
        step();
        reset_n = 1'b1;
        step();

        tab[0]  = '{1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'hFFFFFF88, 2, 32'h10, 32'h8899AABB, 32'h11223344};
        tab[1]  = '{1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 32'h00004488, 3, 32'h10, 32'h8899AABB, 32'h11223344};
        tab[2]  = '{1'b1, 2'b01, 1'b0, 32'h12, 32'h1234, 32'h0, 2, 32'h12, 32'h1234AABB, 32'h11223344};
        tab[3]  = '{1'b1, 2'b00, 1'b0, 32'h11, 32'hDEADBEEF, 32'h0, 5, 32'h11, 32'hADBEEFBB, 32'h112233DE};
        tab[4]  = '{1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 32'h33448899, 3, 32'h10, 32'h8899AABB, 32'h11223344};
        tab[5]  = '{1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'hFFFF99AA, 2, 32'h10, 32'h8899AABB, 32'h11223344};
        tab[6]  = '{1'b0, 2'b10, 1'b1, 32'h14, 32'h0, 32'h00000044, 2, 32'h14, 32'h8899AABB, 32'h11223344};
        tab[7]  = '{1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h8899AABB, 2, 32'h10, 32'h8899AABB, 32'h11223344};
        tab[8]  = '{1'b1, 2'b10, 1'b0, 32'h17, 32'h5A, 32'h0, 2, 32'h17, 32'h8899AABB, 32'h5A223344};
        tab[9]  = '{1'b1, 2'b01, 1'b0, 32'h13, 32'hCAFE, 32'h0, 3, 32'h13, 32'hFE99AABB, 32'h112233CA};
        tab[10] = '{1'b1, 2'b11, 1'b0, 32'h14, 32'h01020304, 32'h0, 2, 32'h14, 32'h8899AABB, 32'h01020304};
        tab[11] = '{1'b0, 2'b00, 1'b1, 32'hFFFFFFFF, 32'h0, 32'h0, 3, 32'hFFFFFFFC, 32'h8899AABB, 32'h11223344};

        for (int i = 0; i < 12; i++) begin
            preload();
            access(tab[i].we, tab[i].size, tab[i].uns, tab[i].addr, tab[i].wdata, 1'b0, lat, rd);
            check($sformatf("vec%0d_latency", i), lat, tab[i].exp_lat);
            check($sformatf("vec%0d_rdata", i), rd, tab[i].exp_rdata);
            check($sformatf("vec%0d_adr0", i), trace[0].adr, tab[i].exp_adr0);
            check($sformatf("vec%0d_word10", i), mem_word(6'h10), tab[i].exp_w10);
            check($sformatf("vec%0d_word14", i), mem_word(6'h14), tab[i].exp_w14);
        end

        // Half store aligned: one full-width write cycle in half mode.
        preload();
        access(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234, 1'b0, lat, rd);
        check("sth_we", trace[0].we, 1);
        check("sth_mode", {30'b0, trace[0].mode}, 32'h1);
        check("sth_wd", trace[0].wd, 32'h1234);

        // Misaligned word store: four byte writes in ascending address order.
        preload();
        access(1'b1, 2'b00, 1'b0, 32'h11, 32'hDEADBEEF, 1'b0, lat, rd);
        wdv = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("stb%0d_we", k), trace[k].we, 1);
            check($sformatf("stb%0d_mode", k), {30'b0, trace[k].mode}, 32'h2);
            check($sformatf("stb%0d_adr", k), trace[k].adr, 32'h11 + k);
            check($sformatf("stb%0d_wd", k), trace[k].wd, {24'b0, wdv[8*k +: 8]});
        end

        // Word load at the top of the address space wraps its second read to 0.
        preload();
        access(1'b0, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0, lat, rd);
        check("wrap_adr0", trace[0].adr, 32'hFFFFFFFC);
        check("wrap_adr1", trace[1].adr, 32'h00000000);

        // Reset asserted during the second byte write of a misaligned word store.
        preload();
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_size = 2'b00;
        bus.req_addr = 32'h11;
        bus.req_wdata = 32'hDEADBEEF;
        step();
        bus.req_valid = 1'b0;
        check("abort_c1_adr", bus.mem_adr, 32'h11);
        step();
        check("abort_c2_we", bus.mem_we, 1);
        check("abort_c2_adr", bus.mem_adr, 32'h12);
        reset_n = 1'b0;
        #1;
        check("abort_mem_we", bus.mem_we, 0);
        check("abort_req_ready", bus.req_ready, 1);
        check("abort_resp_valid", bus.resp_valid, 0);
        check("abort_mem_adr", bus.mem_adr, 0);
        step();
        reset_n = 1'b1;
        n_bad = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.resp_valid || bus.mem_we || !bus.req_ready) n_bad++;
            step();
        end
        check("abort_quiet_cycles", n_bad, 0);
        check("abort_word10", mem_word(6'h10), 32'h8899EFBB);
        check("abort_word14", mem_word(6'h14), 32'h11223344);

        // Randomized accesses with junk on the request lines while busy.
        preload();
        for (int t = 0; t < 300; t++) begin
            logic        we, uns;
            logic [1:0]  size;
            logic [31:0] addr, wdata, exp_adr0;
            we    = 1'($urandom);
            uns   = 1'($urandom);
            size  = 2'($urandom);
            addr  = ($urandom_range(0, 3) == 0) ? $urandom : {26'b0, 6'($urandom)};
            wdata = $urandom;
            exp_rd   = we ? 32'h0 : ref_load(addr, size, uns);
            exp_adr0 = we ? addr : (addr & 32'hFFFFFFFC);
            access(we, size, uns, addr, wdata, 1'b1, lat, rd);
            check($sformatf("rnd%0d_latency", t), lat, ref_latency(we, addr, size));
            check($sformatf("rnd%0d_rdata", t), rd, exp_rd);
            check($sformatf("rnd%0d_adr0", t), trace[0].adr, exp_adr0);
            if (we) ref_store(addr, size, wdata);
            n_bad = 0;
            for (int i = 0; i < 64; i++) if (mb[i] !== rb[i]) n_bad++;
            check($sformatf("rnd%0d_mem_image", t), n_bad, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
